// File: rtl/ram_mov_moc_pkg.sv
// ram_mov_moc_pkg
//   Shared definitions for the MOV/MOC byte memory:
//   - SIZE encodings (byte, halfword, word; 2'b11 is handled as word)
//   - RW encodings (1 = read, 0 = write)
//   - FSM state encoding
//   - lane_mask(): which of the four byte lanes at an aligned word base
//     an access of a given size and lane offset touches.
//     Bit i of the mask is the byte at base+i, where lane 0 is the lowest address.
package ram_mov_moc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The offset is expected to be already aligned to the access size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ram_mov_moc_if.sv
// ram_mov_moc_if
//   Control-unit <-> memory handshake bundle.
//   MOV      : memory operation valid (control unit holds it until MOC)
//   RW       : 1 = read, 0 = write
//   SIZE     : 00 byte, 01 halfword, 10/11 word
//   ADDR     : byte address (only the low bits addressing the array are used)
//   DATA_IN  : right-justified write data
//   DATA_OUT : right-justified, zero-extended read data (registered)
//   MOC      : memory operation complete (registered)
//   master = control unit side, slave = memory side.
interface ram_mov_moc_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  SIZE;
  logic [31:0] ADDR;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        MOC;

  modport master (
    output MOV, RW, SIZE, ADDR, DATA_IN,
    input  DATA_OUT, MOC
  );

  modport slave (
    input  MOV, RW, SIZE, ADDR, DATA_IN,
    output DATA_OUT, MOC
  );
endinterface

// File: rtl/ram_mov_moc_byte_array.sv
// ram_byte_array
//   DEPTH x 8 storage organised as DEPTH/4 words of four byte lanes.
//   Contents have no reset so a bench can preload `memory` hierarchically.
//   clk       : rising-edge clock for writes
//   word_addr : aligned word index (byte address >> 2)
//   we        : per-lane write enable, bit i writes byte at base+i
//   wdata     : lane data, lane 0 in [31:24] ... lane 3 in [7:0]
//   rdata     : asynchronous read of all four lanes, same lane packing
module ram_byte_array #(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic [$clog2(DEPTH)-3:0]   word_addr,
  input  logic [3:0]                 we,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  logic [7:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        memory[{word_addr, 2'(i)}] <= wdata[31-8*i -: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[31-8*i -: 8] = memory[{word_addr, 2'(i)}];
    end
  end

endmodule

// File: rtl/ram_mov_moc.sv
// ram_mov_moc
//   Big-endian DEPTH x 8 memory answering a MOV/MOC handshake.
//   A request is latched when MOV is sampled high in IDLE; after LATENCY
//   edges the access is performed and MOC rises. MOC is held until MOV is
//   sampled low. All outputs are registered.
//   CLK   : rising-edge clock
//   RESET : asynchronous active-low reset (memory contents survive it)
//   bus   : slave side of the MOV/MOC handshake bundle
module ram_mov_moc
  import ram_mov_moc_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic          CLK,
  input logic          RESET,
  ram_mov_moc_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rw_q, rw_d;
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_out_q, data_out_d;
  logic            moc_q, moc_d;

  logic            acc_rw;
  logic [1:0]      acc_size;
  logic [AW-1:0]   acc_addr;
  logic [AW-1:0]   acc_addr_al;
  logic [31:0]     acc_data;
  logic            do_access;
  logic [3:0]      lane_we;
  logic [31:0]     wr_lanes;
  logic [31:0]     rd_lanes;
  logic [31:0]     rd_value;
  logic            unused_addr;

  assign unused_addr = ^bus.ADDR[31:AW];

  // With LATENCY=1 the access happens on the very edge that samples MOV,
  // so the live inputs feed the access; otherwise the latched request does.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_rw   = bus.RW;
      acc_size = bus.SIZE;
      acc_addr = bus.ADDR[AW-1:0];
      acc_data = bus.DATA_IN;
    end else begin
      acc_rw   = rw_q;
      acc_size = size_q;
      acc_addr = addr_q;
      acc_data = wdata_q;
    end
  end

  assign do_access = ((state_q == ST_BUSY) && (cnt_q == '0)) ||
                     ((LATENCY == 1) && (state_q == ST_IDLE) && bus.MOV);

  // Alignment drops the low address bits, so aligned accesses stay inside
  // one word and never wrap past the top of the array.
  always_comb begin
    acc_addr_al = acc_addr;
    if (acc_size[1]) begin
      acc_addr_al[1:0] = 2'b00;
    end else if (acc_size == SZ_HALF) begin
      acc_addr_al[0] = 1'b0;
    end
  end

  // Lane steering: write data is replicated across lanes and the mask picks
  // the live ones; read data is selected from the lanes and zero-extended.
  always_comb begin
    wr_lanes = {4{acc_data[7:0]}};
    rd_value = '0;
    if (acc_size[1]) begin
      wr_lanes = acc_data;
      rd_value = rd_lanes;
    end else if (acc_size == SZ_HALF) begin
      wr_lanes = {2{acc_data[15:0]}};
      rd_value = acc_addr_al[1] ? {16'd0, rd_lanes[15:0]} : {16'd0, rd_lanes[31:16]};
    end else begin
      case (acc_addr_al[1:0])
        2'd0:    rd_value = {24'd0, rd_lanes[31:24]};
        2'd1:    rd_value = {24'd0, rd_lanes[23:16]};
        2'd2:    rd_value = {24'd0, rd_lanes[15:8]};
        default: rd_value = {24'd0, rd_lanes[7:0]};
      endcase
    end
  end

  assign lane_we = (do_access && (acc_rw == RW_WRITE)) ? lane_mask(acc_size, acc_addr_al[1:0]) : 4'b0000;

  ram_byte_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk       (CLK),
    .word_addr (acc_addr_al[AW-1:2]),
    .we        (lane_we),
    .wdata     (wr_lanes),
    .rdata     (rd_lanes)
  );

  // Next-state, request latching, counter and registered outputs.
  // Dropping MOV in BUSY does not abort; DONE is still entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.MOV) begin
          rw_d    = bus.RW;
          size_d  = bus.SIZE;
          addr_d  = bus.ADDR[AW-1:0];
          wdata_d = bus.DATA_IN;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (!bus.MOV) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_access && (acc_rw == RW_READ)) begin
      data_out_d = rd_value;
    end
    moc_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rw_q       <= RW_READ;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      moc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      moc_q      <= moc_d;
    end
  end

  assign bus.DATA_OUT = data_out_q;
  assign bus.MOC      = moc_q;

endmodule

// File: doc/ram_mov_moc.md
# ram_mov_moc

Byte-organised 256×8 data/instruction memory with a MOV/MOC handshake. It sits directly downstream of the datapath's MAR/MDR and answers the control unit's memory states. It latches a request when MOV is high, performs a byte, halfword or word access after a fixed latency, then raises MOC and holds it until the control unit drops MOV. Storage is big-endian and is not cleared by reset, so benches can preload it through the hierarchical array `memory`.

## Interface
- DEPTH, 256: number of bytes; the address is taken modulo DEPTH.
- LATENCY, 2: cycles from the clock edge that samples MOV to MOC rising; legal values ≥1.
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MOV  in  1  memory operation valid; held by the control unit until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- ADDR  in  32  byte address; only [7:0] are used.
- DATA_IN  in  32  write data, right-justified.
- DATA_OUT  out  32  read data, right-justified and zero-extended.
- MOC  out  1  memory operation complete.

## Operation
- State machine with three states: IDLE, BUSY and DONE.
- IDLE
  - MOV=1 at an edge: latch RW, SIZE, ADDR[7:0] and DATA_IN, load cnt=LATENCY-1, then go to BUSY (or to DONE directly if LATENCY=1).
- BUSY
  - Decrement cnt each cycle.
  - At cnt=0, perform the access and go to DONE.
  - Input changes during BUSY are ignored because the request is latched.
- Access
  - Alignment: halfword clears address bit 0; word clears bits [1:0]. Aligned accesses never wrap past byte 255.
  - Big-endian: word mem[a]=D[31:24], mem[a+1]=D[23:16], mem[a+2]=D[15:8], mem[a+3]=D[7:0]. Halfword mem[a]=D[15:8], mem[a+1]=D[7:0]. Byte mem[a]=D[7:0].
  - Read: DATA_OUT is registered with the assembled value; unused upper bits are 0.
  - Write: exactly one memory update, on the BUSY→DONE edge. DATA_OUT is left unchanged.
- DONE
  - MOC=1, and DATA_OUT is stable.
  - Stay in DONE while MOV=1. When MOV=0 at an edge, go to IDLE with MOC=0.
  - A new request needs at least one IDLE cycle with MOV sampled.
- Dropping MOV during BUSY does not abort: the access completes, MOC is high for exactly one cycle, then the block returns to IDLE.
- Reset (async, RESET=0)
  - State goes to IDLE; MOC=0; DATA_OUT=0; cnt=0.
  - An in-flight write that has not reached the DONE edge is discarded.
  - Memory contents are preserved.

## Timing
- Edge E0 samples MOV=1 in IDLE. MOC is high after edge E0+LATENCY; with the default, that is the second edge after E0.
- On a read, DATA_OUT is valid in the same cycle MOC rises.
- MOC falls one edge after MOV is sampled low.
- Back-to-back requests: minimum period is LATENCY+2 cycles (request, latency, release, idle sample).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - SIZE encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encodings: ST_IDLE, ST_BUSY, ST_DONE.
  - RW_READ and RW_WRITE constants.
- One sub-module, `ram_byte_array`, wraps the `memory` array. It has a 4-byte write-enable mask and a 4-lane read at an aligned base.
- The top level contains the FSM, the latency counter, the request latches and the lane steering/zero-extension.

## Test plan
- Reset: assert RESET=0 mid-BUSY during a write of 0xDEADBEEF at 0x10 → MOC=0, DATA_OUT=0 immediately; mem[0x10..0x13] is unchanged (preloaded 0x00).
- Word write then read:
  - Write 0x11223344 at ADDR 0x20 → mem[0x20]=0x11 … mem[0x23]=0x44.
  - Read word at 0x20 → DATA_OUT=0x11223344.
  - With LATENCY=2, MOC rises 2 edges after MOV is sampled.
- Halfword/byte and alignment, with memory holding 0x11223344 at 0x20:
  - Read halfword at 0x23 → DATA_OUT=0x00003344.
  - Read byte at 0x21 → 0x00000022.
  - Write byte 0xAB at 0x22, then read word at 0x20 → 0x1122AB44.
- Handshake hold: keep MOV=1 for 5 cycles after MOC → MOC stays 1 and DATA_OUT is stable. Drop MOV → MOC=0 at the next edge, then IDLE.
- Early MOV drop: pulse MOV for 1 cycle with a write of 0xCAFEF00D at 0x40 → write occurs, MOC is high for exactly 1 cycle, then IDLE.
- Latched inputs and boundary: change ADDR and DATA_IN during BUSY → the original request is used. A word write at 0xFC (0x01020304) updates 0xFC..0xFF only; mem[0x00] is unchanged.
